mem_port_arbiter: RTL and testbench

- Sequences the shared 16K x 16-bit memory array between four processor ports.
- Accepts per-port request/write-enable/address/data and grants one port at a time.
- Issues a single transaction to the memory side, waits for acknowledge, then returns read data and a one-cycle response pulse to the granted port.
- Replaces ad-hoc combinational priority selection with a registered, fair, handshaked controller.

---
 rtl/mem_arb_pkg.sv | 37 +++
 rtl/mem_arb_picker.sv | 18 +
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// four-port memory arbiter.
package mem_arb_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 16;
    localparam int PID_W     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // First requesting port found when scanning upward from ptr, wrapping 3->0.
    // Returns ptr when nothing is requesting (caller qualifies with any-request).
    function automatic logic [PID_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [PID_W-1:0]     ptr);
        logic [PID_W-1:0] idx;
        logic [PID_W-1:0] win;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = ptr + PID_W'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational 4-way selector: scans requests starting at the pointer.
// A pointer tied to zero gives fixed priority with port 0 highest.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PID_W-1:0]     ptr,
    output logic [PID_W-1:0]     win,
    output logic                 any
);

    // Winner index and "someone is asking" flag.
    always_comb begin
        win = rr_pick(req, ptr);
        any = |req;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Four-port arbiter for the shared 16K x 16 memory array.
// One transaction at a time: IDLE picks a port and latches its command,
// ACCESS holds mem_req until mem_ack, RESP pulses proc_resp to the winner.
// Build option: define MEM_PORT_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority (port 0 highest) with no pointer register.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              proc_req,
    input  logic [NUM_PORTS-1:0]              proc_we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  proc_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  proc_wdata,
    output logic [NUM_PORTS-1:0]              proc_resp,
    output logic [DATA_W-1:0]                 proc_rdata,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic                              mem_ack,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              busy,
    output logic [PID_W-1:0]                  grant_id
);

    arb_state_t             state_r, state_nxt_s;
    logic [PID_W-1:0]       grant_id_r, grant_nxt_s;
    logic                   mem_req_r, mem_req_nxt_s;
    logic                   mem_we_r, mem_we_nxt_s;
    logic [ADDR_W-1:0]      mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0]      mem_wdata_r, mem_wdata_nxt_s;
    logic [NUM_PORTS-1:0]   proc_resp_r, proc_resp_nxt_s;
    logic [DATA_W-1:0]      proc_rdata_r, proc_rdata_nxt_s;
    logic                   busy_r;
    logic [PID_W-1:0]       ptr_s;
    logic [PID_W-1:0]       win_s;
    logic                   req_any_s;

`ifdef MEM_PORT_ARB_RR_EN
    logic [PID_W-1:0]       ptr_r;

    // Round-robin pointer moves past the port just served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= 2'd0;
        end else if (state_r == RESP) begin
            ptr_r <= grant_id_r + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = 2'd0;
`endif

    mem_arb_picker u_picker (
        .req (proc_req),
        .ptr (ptr_s),
        .win (win_s),
        .any (req_any_s)
    );

    // Next-state and next-register values; everything holds unless told otherwise.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_id_r;
        mem_req_nxt_s    = 1'b0;
        mem_we_nxt_s     = mem_we_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        proc_resp_nxt_s  = 4'b0000;
        proc_rdata_nxt_s = proc_rdata_r;
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    state_nxt_s     = ACCESS;
                    grant_nxt_s     = win_s;
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = proc_we[win_s];
                    mem_addr_nxt_s  = proc_addr[win_s];
                    mem_wdata_nxt_s = proc_wdata[win_s];
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_nxt_s     = RESP;
                    proc_resp_nxt_s = 4'b0001 << grant_id_r;
                    if (!mem_we_r) begin
                        proc_rdata_nxt_s = mem_rdata;
                    end else begin
                        proc_rdata_nxt_s = proc_rdata_r;
                    end
                end else begin
                    state_nxt_s   = ACCESS;
                    mem_req_nxt_s = 1'b1;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops mem_req at once and clears any response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_id_r   <= 2'd0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 14'd0;
            mem_wdata_r  <= 16'd0;
            proc_resp_r  <= 4'b0000;
            proc_rdata_r <= 16'd0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            grant_id_r   <= grant_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            proc_resp_r  <= proc_resp_nxt_s;
            proc_rdata_r <= proc_rdata_nxt_s;
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

    assign proc_resp  = proc_resp_r;
    assign proc_rdata = proc_rdata_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign busy       = busy_r;
    assign grant_id   = grant_id_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. The memory side is
// driven by hand so ack timing is exact. Contention expectations follow
// the MEM_PORT_ARB_RR_EN build option.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic                              clk;
    logic                              reset;
    logic [NUM_PORTS-1:0]              proc_req;
    logic [NUM_PORTS-1:0]              proc_we;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  proc_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  proc_wdata;
    logic [NUM_PORTS-1:0]              proc_resp;
    logic [DATA_W-1:0]                 proc_rdata;
    logic                              mem_req;
    logic                              mem_we;
    logic [ADDR_W-1:0]                 mem_addr;
    logic [DATA_W-1:0]                 mem_wdata;
    logic                              mem_ack;
    logic [DATA_W-1:0]                 mem_rdata;
    logic                              busy;
    logic [PID_W-1:0]                  grant_id;

    int checks_cnt;
    int fail_cnt;
    int exp_order[5];

    mem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .proc_req   (proc_req),
        .proc_we    (proc_we),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_resp  (proc_resp),
        .proc_rdata (proc_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
`ifdef MEM_PORT_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        reset      = 1'b1;
        proc_req   = 4'b0000;
        proc_we    = 4'b0000;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        pulse_reset();

        // Reset state
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_grant", 32'(grant_id), 32'd0);
        check_val("rst_resp", 32'(proc_resp), 32'd0);
        check_val("rst_rdata", 32'(proc_rdata), 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);

        // mem_ack while idle is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("idle_ack_busy", 32'(busy), 32'd0);
        tick();
        check_val("idle_ack_resp", 32'(proc_resp), 32'd0);

        // Single read on port 0, ack in first ACCESS cycle
        proc_req     = 4'b0001;
        proc_we      = 4'b0000;
        proc_addr[0] = 14'h0005;
        tick();
        check_val("rd_mem_req", 32'(mem_req), 32'd1);
        check_val("rd_mem_addr", 32'(mem_addr), 32'h0005);
        check_val("rd_mem_we", 32'(mem_we), 32'd0);
        check_val("rd_busy", 32'(busy), 32'd1);
        check_val("rd_resp_early", 32'(proc_resp), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h0006;
        tick();
        mem_ack  = 1'b0;
        proc_req = 4'b0000;
        check_val("rd_resp", 32'(proc_resp), 32'b0001);
        check_val("rd_rdata", 32'(proc_rdata), 32'h0006);
        check_val("rd_mem_req_off", 32'(mem_req), 32'd0);
        tick();
        check_val("rd_resp_once", 32'(proc_resp), 32'd0);
        check_val("rd_idle", 32'(busy), 32'd0);

        // Write on port 2, ack after 4 waiting cycles
        proc_req      = 4'b0100;
        proc_we       = 4'b0100;
        proc_addr[2]  = 14'h1234;
        proc_wdata[2] = 16'hBEEF;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_val("wr_mem_req", 32'(mem_req), 32'd1);
            check_val("wr_mem_we", 32'(mem_we), 32'd1);
            check_val("wr_wdata", 32'(mem_wdata), 32'hBEEF);
            check_val("wr_addr", 32'(mem_addr), 32'h1234);
            check_val("wr_wait_resp", 32'(proc_resp), 32'd0);
            if (i == 4) mem_ack = 1'b1;
            tick();
        end
        mem_ack  = 1'b0;
        proc_req = 4'b0000;
        proc_we  = 4'b0000;
        check_val("wr_resp", 32'(proc_resp), 32'b0100);
        check_val("wr_grant", 32'(grant_id), 32'd2);
        check_val("wr_rdata_kept", 32'(proc_rdata), 32'h0006);
        tick();
        check_val("wr_resp_once", 32'(proc_resp), 32'd0);

        // Contention: all four ports held high from a fresh reset
        pulse_reset();
        for (int p = 0; p < 4; p++) proc_addr[p] = 14'(16 + p);
        proc_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            tick();
            check_val("cont_grant", 32'(grant_id), 32'(exp_order[t]));
            check_val("cont_addr", 32'(mem_addr), 32'(16 + exp_order[t]));
            mem_ack   = 1'b1;
            mem_rdata = 16'(16'hA000 + t);
            tick();
            mem_ack = 1'b0;
            check_val("cont_resp", 32'(proc_resp), 32'(4'b0001 << exp_order[t]));
            check_val("cont_rdata", 32'(proc_rdata), 32'(16'hA000 + t));
            if (t == 4) proc_req = 4'b0000;
            tick();
        end
        check_val("cont_idle", 32'(busy), 32'd0);

        // Port 1 changes address and drops request mid-ACCESS
        proc_req     = 4'b0010;
        proc_addr[1] = 14'h0AAA;
        tick();
        check_val("mid_grant", 32'(grant_id), 32'd1);
        proc_addr[1] = 14'h0555;
        proc_req     = 4'b0000;
        tick();
        check_val("mid_addr_hold", 32'(mem_addr), 32'h0AAA);
        check_val("mid_mem_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("mid_resp", 32'(proc_resp), 32'b0010);
        tick();
        check_val("mid_resp_once", 32'(proc_resp), 32'd0);

        // Reset during ACCESS aborts the transaction
        proc_req     = 4'b0001;
        proc_addr[0] = 14'h0033;
        tick();
        check_val("abort_pre_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("abort_async_req", 32'(mem_req), 32'd0);
        proc_req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        tick();
        check_val("abort_no_resp", 32'(proc_resp), 32'd0);
        proc_req     = 4'b1000;
        proc_addr[3] = 14'h3FFF;
        tick();
        check_val("post_grant", 32'(grant_id), 32'd3);
        check_val("post_addr", 32'(mem_addr), 32'h3FFF);
        mem_ack = 1'b1;
        tick();
        mem_ack  = 1'b0;
        proc_req = 4'b0000;
        check_val("post_resp", 32'(proc_resp), 32'b1000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
